// File: rtl/bcd_score_counter.sv
// BCD score counter with decimal ripple-carry add, sticky overflow, high-score
// tracking and active-low seven-segment decode of the live score.
module bcd_score_counter #(
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  add_valid,
    input  logic [3:0]            add_amt,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [7*DIGITS-1:0]   hex_out,
    output logic                  overflow,
    output logic                  new_high,
    output logic                  add_err
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned HW = 7 * DIGITS;
    localparam logic [SW-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [SW-1:0] score_q, score_d;
    logic [SW-1:0] high_q, high_d;
    logic          overflow_q, overflow_d;
    logic          new_high_q, new_high_d;
    logic          add_err_q, add_err_d;

    logic [SW-1:0] sum_bcd;
    logic          carry_out;
    logic [4:0]    dsum;
    logic          carry;
    logic          add_ok;
    logic [HW-1:0] hex_c;
    logic          lead_zero;
    logic [3:0]    dig;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign add_ok = add_valid && (add_amt <= 4'd9);

    // Decimal ripple add: add_amt enters digit 0, carry propagates to the top.
    always_comb begin
        sum_bcd   = '0;
        dsum      = '0;
        carry     = 1'b0;
        carry_out = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dsum = 5'(score_q[4*i +: 4]) + 5'(carry);
            if (i == 0) begin
                dsum = dsum + 5'(add_amt);
            end
            if (dsum > 5'd9) begin
                dsum  = dsum - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            sum_bcd[4*i +: 4] = dsum[3:0];
        end
        carry_out = carry;
    end

    always_comb begin
        score_d    = score_q;
        high_d     = high_q;
        overflow_d = overflow_q;
        new_high_d = 1'b0;
        add_err_d  = add_valid && (add_amt > 4'd9);

        if (clear) begin
            score_d    = '0;
            overflow_d = 1'b0;
        end else if (add_ok) begin
            if (carry_out) begin
                overflow_d = 1'b1;
                score_d    = (SATURATE != 0) ? ALL_NINES : sum_bcd;
            end else begin
                score_d = sum_bcd;
            end
        end

        // Packed BCD orders like the decimal value, so a plain compare suffices.
        if ((score_q > high_q) && !((SATURATE == 0) && overflow_q)) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q    <= '0;
            high_q     <= '0;
            overflow_q <= 1'b0;
            new_high_q <= 1'b0;
            add_err_q  <= 1'b0;
        end else begin
            score_q    <= score_d;
            high_q     <= high_d;
            overflow_q <= overflow_d;
            new_high_q <= new_high_d;
            add_err_q  <= add_err_d;
        end
    end

    // Scan from the top digit; digits above the first nonzero one may be blanked.
    always_comb begin
        hex_c     = '0;
        lead_zero = 1'b1;
        dig       = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            dig = score_q[4*i +: 4];
            if (dig != 4'd0) begin
                lead_zero = 1'b0;
            end
            if ((BLANK_LZ != 0) && lead_zero && (i != 0)) begin
                hex_c[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_c[7*i +: 7] = seg7(dig);
            end
        end
    end

    assign score_bcd = score_q;
    assign high_bcd  = high_q;
    assign overflow  = overflow_q;
    assign new_high  = new_high_q;
    assign add_err   = add_err_q;
    assign hex_out   = hex_c;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Self-checking bench: wrap/no-blank and saturate/blank instances share stimulus
// and are compared against an integer score model plus directed vectors.
module tb_bcd_score_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        add_valid = 1'b0;
    logic [3:0]  add_amt = 4'd0;

    logic [11:0] w_score, w_high, s_score, s_high;
    logic [20:0] w_hex, s_hex;
    logic        w_ovf, w_nh, w_err, s_ovf, s_nh, s_err;

    int errors = 0;
    int checks = 0;

    int m_score [2];
    int m_high  [2];
    bit m_ovf   [2];
    bit m_nh    [2];
    bit m_err;

    logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    typedef struct {
        bit          v;
        int          amt;
        bit          clr;
        logic [11:0] exp_score;
        logic [11:0] exp_high;
        bit          exp_nh;
        bit          exp_err;
    } vec_t;

    vec_t vecs [11];

    bcd_score_counter #(.DIGITS(3), .SATURATE(0), .BLANK_LZ(0)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .add_valid(add_valid), .add_amt(add_amt),
        .score_bcd(w_score), .high_bcd(w_high), .hex_out(w_hex),
        .overflow(w_ovf), .new_high(w_nh), .add_err(w_err)
    );

    bcd_score_counter #(.DIGITS(3), .SATURATE(1), .BLANK_LZ(1)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .add_valid(add_valid), .add_amt(add_amt),
        .score_bcd(s_score), .high_bcd(s_high), .hex_out(s_hex),
        .overflow(s_ovf), .new_high(s_nh), .add_err(s_err)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [20:0] exp_hex(input int v, input bit blank);
        logic [20:0] h;
        int nd;
        int p;
        nd = (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
        p  = 1;
        h  = '0;
        for (int d = 0; d < 3; d++) begin
            if (blank && d >= nd) h[7*d +: 7] = 7'b1111111;
            else                  h[7*d +: 7] = segtab[(v / p) % 10];
            p = p * 10;
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_score[k] = 0; m_high[k] = 0; m_ovf[k] = 0; m_nh[k] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_step(input bit v, input int amt, input bit clr);
        int s;
        for (int k = 0; k < 2; k++) begin
            m_nh[k] = (m_score[k] > m_high[k]) && !(k == 0 && m_ovf[k]);
            if (m_nh[k]) m_high[k] = m_score[k];
            if (clr) begin
                m_score[k] = 0;
                m_ovf[k]   = 0;
            end else if (v && amt <= 9) begin
                s = m_score[k] + amt;
                if (s > 999) begin
                    m_ovf[k]   = 1;
                    m_score[k] = (k == 1) ? 999 : s - 1000;
                end else begin
                    m_score[k] = s;
                end
            end
        end
        m_err = v && amt > 9;
    endtask

    task automatic check_all();
        chk("w_score", 64'(w_score), 64'(to_bcd(m_score[0])));
        chk("w_high",  64'(w_high),  64'(to_bcd(m_high[0])));
        chk("w_hex",   64'(w_hex),   64'(exp_hex(m_score[0], 1'b0)));
        chk("w_ovf",   64'(w_ovf),   64'(m_ovf[0]));
        chk("w_nh",    64'(w_nh),    64'(m_nh[0]));
        chk("w_err",   64'(w_err),   64'(m_err));
        chk("s_score", 64'(s_score), 64'(to_bcd(m_score[1])));
        chk("s_high",  64'(s_high),  64'(to_bcd(m_high[1])));
        chk("s_hex",   64'(s_hex),   64'(exp_hex(m_score[1], 1'b1)));
        chk("s_ovf",   64'(s_ovf),   64'(m_ovf[1]));
        chk("s_nh",    64'(s_nh),    64'(m_nh[1]));
        chk("s_err",   64'(s_err),   64'(m_err));
    endtask

    task automatic cycle(input bit v, input int amt, input bit clr);
        @(negedge clk);
        add_valid = v;
        add_amt   = 4'(amt);
        clear     = clr;
        @(posedge clk);
        model_step(v, amt, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; add_valid = 1'b0; clear = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic add_up(input int total);
        int rem;
        rem = total;
        while (rem > 0) begin
            cycle(1'b1, (rem > 9) ? 9 : rem, 1'b0);
            rem = rem - ((rem > 9) ? 9 : rem);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1,  7, 1'b0, 12'h007, 12'h000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1,  0, 1'b0, 12'h007, 12'h007, 1'b1, 1'b0};
        vecs[2]  = '{1'b1,  3, 1'b0, 12'h010, 12'h007, 1'b0, 1'b0};
        vecs[3]  = '{1'b0,  0, 1'b0, 12'h010, 12'h010, 1'b1, 1'b0};
        vecs[4]  = '{1'b1,  5, 1'b1, 12'h000, 12'h010, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 12, 1'b0, 12'h000, 12'h010, 1'b0, 1'b1};
        vecs[6]  = '{1'b0,  0, 1'b0, 12'h000, 12'h010, 1'b0, 1'b0};
        vecs[7]  = '{1'b1,  9, 1'b0, 12'h009, 12'h010, 1'b0, 1'b0};
        vecs[8]  = '{1'b1,  1, 1'b0, 12'h010, 12'h010, 1'b0, 1'b0};
        vecs[9]  = '{1'b1,  1, 1'b0, 12'h011, 12'h010, 1'b0, 1'b0};
        vecs[10] = '{1'b0,  0, 1'b0, 12'h011, 12'h011, 1'b1, 1'b0};

        model_reset();
        do_reset();

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].v, vecs[i].amt, vecs[i].clr);
            chk($sformatf("vec%0d_score", i), 64'(w_score), 64'(vecs[i].exp_score));
            chk($sformatf("vec%0d_high", i),  64'(w_high),  64'(vecs[i].exp_high));
            chk($sformatf("vec%0d_nh", i),    64'(w_nh),    64'(vecs[i].exp_nh));
            chk($sformatf("vec%0d_err", i),   64'(w_err),   64'(vecs[i].exp_err));
        end

        // Decimal carry across two digits.
        do_reset();
        add_up(98);
        cycle(1'b1, 4, 1'b0);
        chk("carry_score", 64'(w_score), 64'(12'h102));
        chk("carry_hex0",  64'(w_hex[6:0]), 64'(7'b0100100));
        chk("carry_ovf",   64'(w_ovf), 64'(1'b0));

        // Wrap vs saturate from 997, then clear.
        do_reset();
        add_up(997);
        cycle(1'b1, 5, 1'b0);
        chk("wrap_score", 64'(w_score), 64'(12'h002));
        chk("wrap_ovf",   64'(w_ovf),   64'(1'b1));
        chk("sat_score",  64'(s_score), 64'(12'h999));
        cycle(1'b0, 0, 1'b0);
        chk("wrap_high_held", 64'(w_high), 64'(12'h997));
        cycle(1'b1, 1, 1'b0);
        chk("sat_hold", 64'(s_score), 64'(12'h999));
        cycle(1'b0, 0, 1'b1);
        chk("clr_score", 64'(w_score), 64'(12'h000));
        chk("clr_ovf",   64'(w_ovf),   64'(1'b0));
        chk("clr_high",  64'(w_high),  64'(12'h997));

        // Saturate from 995.
        do_reset();
        add_up(995);
        cycle(1'b1, 9, 1'b0);
        chk("sat995_score", 64'(s_score), 64'(12'h999));
        chk("sat995_ovf",   64'(s_ovf),   64'(1'b1));
        cycle(1'b1, 1, 1'b0);
        chk("sat995_hold", 64'(s_score), 64'(12'h999));

        // Async reset during a new_high pulse with an add pending.
        do_reset();
        add_up(42);
        cycle(1'b0, 0, 1'b0);
        chk("pre_rst_nh", 64'(s_nh), 64'(1'b1));
        @(negedge clk);
        add_valid = 1'b1; add_amt = 4'd3;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("rst_s_hex", 64'(s_hex), 64'({7'b1111111, 7'b1111111, 7'b1000000}));
        chk("rst_w_hex", 64'(w_hex), 64'({7'b1000000, 7'b1000000, 7'b1000000}));
        chk("rst_nh",    64'(s_nh),  64'(1'b0));
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0; add_valid = 1'b1; add_amt = 4'd5;
        @(posedge clk);
        model_step(1'b1, 5, 1'b0);
        #1;
        check_all();
        chk("post_rst_score", 64'(s_score), 64'(12'h005));

        // Randomized traffic against the integer model.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                  $urandom_range(0, 59) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
